// File: rtl/button_conditioner.sv
// Push-button front end: per-channel two-flop synchroniser, debounce FSM,
// press pulse, and auto-repeat while held.
module button_conditioner #(
  parameter int WIDTH           = 5,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_level,
  output logic [WIDTH-1:0] btn_press,
  output logic [WIDTH-1:0] btn_held
);

  localparam int HR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW     = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW     = $clog2(HR_MAX) + 1;

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] R_LAST = HW'(REPEAT_CYCLES - 1);
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [HW-1:0] H_ONE  = HW'(1);

  typedef enum logic [1:0] {
    LOW    = 2'd0,
    HIGH   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  // Stage p0/p1: metastability guard for the asynchronous button inputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  for (genvar c = 0; c < WIDTH; c++) begin : g_chan
    state_t          state;
    state_t          state_nxt;
    logic [DW-1:0]   dcnt;
    logic [DW-1:0]   dcnt_nxt;
    logic [HW-1:0]   hcnt;
    logic [HW-1:0]   hcnt_nxt;
    logic            level_q;
    logic            press_q;
    logic            held_q;
    logic            level_nxt;
    logic            press_nxt;
    logic            held_nxt;
    logic            sync_c;

    assign sync_c = sync_p1[c];

    // Stage p2: debounce / hold FSM, all outputs taken straight from flops
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state   <= LOW;
        dcnt    <= '0;
        hcnt    <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        held_q  <= 1'b0;
      end else begin
        state   <= state_nxt;
        dcnt    <= dcnt_nxt;
        hcnt    <= hcnt_nxt;
        level_q <= level_nxt;
        press_q <= press_nxt;
        held_q  <= held_nxt;
      end
    end

    always_comb begin
      state_nxt = state;
      dcnt_nxt  = dcnt;
      hcnt_nxt  = hcnt;
      level_nxt = level_q;
      press_nxt = 1'b0;
      held_nxt  = held_q;
      case (state)
        LOW: begin
          if (sync_c) begin
            if (dcnt == D_LAST) begin
              state_nxt = HIGH;
              level_nxt = 1'b1;
              press_nxt = 1'b1;
              dcnt_nxt  = '0;
              hcnt_nxt  = '0;
            end else begin
              dcnt_nxt = dcnt + D_ONE;
            end
          end else begin
            dcnt_nxt = '0;
          end
        end
        HIGH, REPEAT: begin
          // An accepted release overrides a coincident hold/repeat terminal count
          if (!sync_c && dcnt == D_LAST) begin
            state_nxt = LOW;
            level_nxt = 1'b0;
            held_nxt  = 1'b0;
            dcnt_nxt  = '0;
            hcnt_nxt  = '0;
          end else begin
            dcnt_nxt = sync_c ? '0 : dcnt + D_ONE;
            if (state == HIGH) begin
              if (hcnt == H_LAST) begin
                state_nxt = REPEAT;
                held_nxt  = 1'b1;
                press_nxt = 1'b1;
                hcnt_nxt  = '0;
              end else begin
                hcnt_nxt = hcnt + H_ONE;
              end
            end else begin
              if (hcnt == R_LAST) begin
                press_nxt = 1'b1;
                hcnt_nxt  = '0;
              end else begin
                hcnt_nxt = hcnt + H_ONE;
              end
            end
          end
        end
        default: begin
          state_nxt = LOW;
        end
      endcase
    end

    assign btn_level[c] = level_q;
    assign btn_press[c] = press_q;
    assign btn_held[c]  = held_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: two instances (fast and default hold
// timing) checked every cycle against a history-based reference model.
module tb_button_conditioner;

  localparam int W = 5;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic [W-1:0] btn_in;
  logic [W-1:0] level_a, press_a, held_a;
  logic [W-1:0] level_b, press_b, held_b;

  button_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(8), .REPEAT_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(level_a), .btn_press(press_a), .btn_held(held_a)
  );

  button_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut_b (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .btn_level(level_b), .btn_press(press_b), .btn_held(held_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
    end
  endtask

  // Reference model: accept a level change once the last D synchronised samples
  // all disagree with the current level; pulses derived from age since press.
  logic [W-1:0] m_s1[2], m_s2[2], m_lvl[2], m_prs[2], m_hld[2];
  logic [D-1:0] m_hist[2][W];
  int           m_age[2][W];

  function automatic int hold_of(input int m);
    return (m == 0) ? 8 : 64;
  endfunction

  function automatic int rep_of(input int m);
    return (m == 0) ? 4 : 16;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_s1[m] = '0; m_s2[m] = '0; m_lvl[m] = '0; m_prs[m] = '0; m_hld[m] = '0;
      for (int c = 0; c < W; c++) begin
        m_hist[m][c] = '0;
        m_age[m][c]  = 0;
      end
    end
  endtask

  task automatic model_step(input logic [W-1:0] b);
    logic smp;
    int   h, r;
    for (int m = 0; m < 2; m++) begin
      h = hold_of(m);
      r = rep_of(m);
      for (int c = 0; c < W; c++) begin
        smp          = m_s2[m][c];
        m_s2[m][c]   = m_s1[m][c];
        m_s1[m][c]   = b[c];
        m_hist[m][c] = {m_hist[m][c][D-2:0], smp};
        m_prs[m][c]  = 1'b0;
        if (!m_lvl[m][c]) begin
          if (&m_hist[m][c]) begin
            m_lvl[m][c] = 1'b1;
            m_prs[m][c] = 1'b1;
            m_age[m][c] = 0;
          end
        end else if (m_hist[m][c] == '0) begin
          m_lvl[m][c] = 1'b0;
          m_hld[m][c] = 1'b0;
        end else begin
          m_age[m][c]++;
          if (m_age[m][c] == h) begin
            m_hld[m][c] = 1'b1;
            m_prs[m][c] = 1'b1;
          end else if (m_age[m][c] > h && ((m_age[m][c] - h) % r) == 0) begin
            m_prs[m][c] = 1'b1;
          end
        end
      end
    end
  endtask

  typedef struct packed {
    logic [W-1:0] la, pa, ha, lb, pb, hb;
  } exp_t;

  exp_t sb_q[$];

  task automatic tick(input logic [W-1:0] b);
    exp_t e;
    btn_in = b;
    model_step(b);
    e = '{la: m_lvl[0], pa: m_prs[0], ha: m_hld[0], lb: m_lvl[1], pb: m_prs[1], hb: m_hld[1]};
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    cyc++;
    e = sb_q.pop_front();
    check_val("level_a", level_a, e.la);
    check_val("press_a", press_a, e.pa);
    check_val("held_a",  held_a,  e.ha);
    check_val("level_b", level_b, e.lb);
    check_val("press_b", press_b, e.pb);
    check_val("held_b",  held_b,  e.hb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rise, fall, npress, acc, hr, hf, lf, post, p0, p1, low_seen;
    int pe[$];
    logic [W-1:0] b, cur;
    logic [7:0]   pat;
    int run[W];

    rst    = 1'b0;
    btn_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_a", {level_a, press_a, held_a}, 0);
    check_val("reset_b", {level_b, press_b, held_b}, 0);
    rst = 1'b1;

    // Clean press/release on channel 0
    cyc = 0; rise = -1; fall = -1; npress = 0;
    for (int i = 1; i <= 60; i++) begin
      tick((i >= 10 && i < 40) ? 5'b00001 : 5'b00000);
      if (level_b[0] && rise < 0) rise = cyc;
      if (!level_b[0] && rise >= 0 && fall < 0) fall = cyc;
      if (press_b[0]) npress++;
    end
    check_val("t1_rise", rise, 15);
    check_val("t1_fall", fall, 45);
    check_val("t1_npress", npress, 1);

    // Bounce rejection on channel 1
    cyc = 0; acc = 0; pat = 8'b11100111;
    for (int i = 0; i < 20; i++) begin
      b = '0;
      if (i < 8) b[1] = pat[7-i];
      tick(b);
      acc = acc | level_a[1] | press_a[1] | held_a[1] | level_b[1] | press_b[1] | held_b[1];
    end
    check_val("t2_quiet", acc, 0);

    // Auto-repeat on channel 0; release lands on a repeat terminal count
    cyc = 0; hr = -1; hf = -1; lf = -1; pe.delete();
    for (int i = 1; i <= 45; i++) begin
      tick((i <= 32) ? 5'b00001 : 5'b00000);
      if (press_a[0]) pe.push_back(cyc);
      if (held_a[0] && hr < 0) hr = cyc;
      if (!held_a[0] && hr >= 0 && hf < 0) hf = cyc;
      if (!level_a[0] && hr >= 0 && lf < 0) lf = cyc;
    end
    check_val("t3_npulse", pe.size(), 7);
    p0 = (pe.size() > 0) ? pe[0] : -100;
    check_val("t3_e0", p0, 6);
    if (pe.size() >= 4) begin
      check_val("t3_rep1", pe[1] - p0, 8);
      check_val("t3_rep2", pe[2] - p0, 12);
      check_val("t3_rep3", pe[3] - p0, 16);
    end
    check_val("t3_held_rise", hr - p0, 8);
    check_val("t3_level_fall", lf, 38);
    check_val("t3_fall_together", hf, lf);
    post = 0;
    foreach (pe[k]) if (pe[k] >= lf) post++;
    check_val("t3_post_release", post, 0);

    // Release bounce on channel 2 while in HIGH
    cyc = 0; low_seen = 0; rise = -1; pe.delete();
    for (int i = 1; i <= 32; i++) begin
      b = '0;
      b[2] = (i <= 6) || (i >= 10 && i <= 20);
      tick(b);
      if (level_a[2] && rise < 0) rise = cyc;
      if (rise >= 0 && cyc <= 20 && !level_a[2]) low_seen = 1;
      if (press_a[2]) pe.push_back(cyc);
    end
    check_val("t4_rise", rise, 6);
    check_val("t4_level_held", low_seen, 0);
    p1 = (pe.size() > 1) ? pe[1] - pe[0] : -1;
    check_val("t4_repeat_gap", p1, 8);

    // Asynchronous reset while channel 0 is auto-repeating
    cyc = 0;
    for (int i = 1; i <= 20; i++) tick(5'b00001);
    check_val("t5_in_repeat", held_a[0], 1);
    #2 rst = 1'b0;
    #1;
    check_val("t5_async_a", {level_a, press_a, held_a}, 0);
    check_val("t5_async_b", {level_b, press_b, held_b}, 0);
    @(posedge clk);
    #1;
    check_val("t5_hold_a", {level_a, press_a, held_a}, 0);
    rst = 1'b1;
    model_reset();
    cyc = 0; rise = -1; hr = -1;
    for (int i = 1; i <= 30; i++) begin
      tick((i <= 20) ? 5'b00001 : 5'b00000);
      if (press_a[0] && rise < 0) rise = cyc;
      if (held_a[0] && hr < 0) hr = cyc;
    end
    check_val("t5_repress", rise, 6);
    check_val("t5_held_rise", hr, 14);

    // Channel 3 press alongside channel 4 bounce
    cyc = 0; rise = -1; fall = -1; npress = 0; acc = 0;
    for (int i = 1; i <= 45; i++) begin
      b = '0;
      b[3] = (i >= 3 && i < 30);
      if (i >= 3 && i <= 10) b[4] = pat[10-i];
      tick(b);
      if (level_b[3] && rise < 0) rise = cyc;
      if (!level_b[3] && rise >= 0 && fall < 0) fall = cyc;
      if (press_b[3]) npress++;
      acc = acc | level_a[4] | press_a[4] | held_a[4] | level_b[4] | press_b[4] | held_b[4];
    end
    check_val("t6_rise", rise, 8);
    check_val("t6_fall", fall, 35);
    check_val("t6_npress", npress, 1);
    check_val("t6_ch4_quiet", acc, 0);

    // Random mix of glitches and long holds on all channels
    cur = '0;
    for (int c = 0; c < W; c++) run[c] = 0;
    for (int t = 0; t < 600; t++) begin
      for (int c = 0; c < W; c++) begin
        if (run[c] == 0) begin
          cur[c] = ~cur[c];
          run[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(15, 40)) : int'($urandom_range(1, 6));
        end
        run[c]--;
      end
      tick(cur);
    end
    for (int t = 0; t < 10; t++) tick('0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
